fb_write_scheduler: RTL and testbench

Frame-buffer write-side controller for the 320x240 RGB565 VGA path. It shares a single BRAM write port between two pixel requesters and an internal fill (clear) engine. It maps (x,y) pixels onto the packed two-pixels-per-32-bit-word, byte-addressed layout that the VGA scan-out reads. It also double-buffers: requested buffer swaps take effect only at the vsync falling edge, and the base of the displayed buffer is exported to the scan-out side.

---
 rtl/fb_pkg.sv | 10 +
 rtl/fb_rr_arbiter.sv | 16 +
 rtl/fb_write_scheduler.sv | 109 ++++++++++
 tb/tb_fb_write_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and write-scheduler types, shared with the VGA scan-out.
package fb_pkg;
  localparam logic [31:0] H_RES = 32'd320;
  localparam logic [31:0] V_RES = 32'd240;
  localparam logic [31:0] BUF_BYTES = H_RES * V_RES * 2;
  localparam logic [31:0] FILL_WORDS = H_RES * V_RES / 2;
  localparam int PIX_W = 16;
  localparam int WORD_W = 32;
  typedef enum logic {IDLE, FILL} fb_state_t;
endpackage

// File: rtl/fb_rr_arbiter.sv
// fb_rr_arbiter: 2-way round-robin arbiter with a block input; req0 wins the first tie.
module fb_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_block,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);
  logic r_rr_last;
  assign o_grant[0] = !i_block && i_valid[0] && (!i_valid[1] || r_rr_last);
  assign o_grant[1] = !i_block && i_valid[1] && (!i_valid[0] || !r_rr_last);
  always_ff @(posedge clk) begin
    if (!reset) r_rr_last <= 1'b1;
    else if (|o_grant) r_rr_last <= o_grant[1];
  end
endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: shares one BRAM write port between two pixel requesters and a
// back-buffer fill engine; buffer swaps are applied on the vsync falling edge.
module fb_write_scheduler
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_vsync,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [8:0]        req0_x,
  input  logic [7:0]        req0_y,
  input  logic [PIX_W-1:0]  req0_pixel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [8:0]        req1_x,
  input  logic [7:0]        req1_y,
  input  logic [PIX_W-1:0]  req1_pixel,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              fill_busy,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic [31:0]       front_base,
  output logic              write_drop,
  output logic [31:0]       bram_addr,
  output logic [WORD_W-1:0] bram_dout,
  output logic [3:0]        bram_we,
  output logic              bram_en
);
  fb_state_t r_state;
  logic r_live, r_vsync_d, r_front_sel;
  logic [PIX_W-1:0] r_fill_color;
  logic [15:0] r_idx;
  logic [31:0] r_fill_base;
  logic [1:0] w_grant;
  logic w_idle, w_start, w_fall, w_apply, w_oob, w_wr;
  logic [8:0] w_x;
  logic [7:0] w_y;
  logic [PIX_W-1:0] w_pix;
  logic [31:0] w_back_base, w_offset;
  // fill_busy lingers one cycle past the last fill word; treat that cycle as busy too
  assign w_idle = r_state == IDLE && !fill_busy;
  assign w_start = w_idle && fill_start;
  assign w_fall = r_vsync_d && !vga_vsync;
  assign w_apply = w_fall && swap_pending && w_idle;
  assign w_back_base = r_front_sel ? 32'd0 : BUF_BYTES;
  assign w_x = w_grant[1] ? req1_x : req0_x;
  assign w_y = w_grant[1] ? req1_y : req0_y;
  assign w_pix = w_grant[1] ? req1_pixel : req0_pixel;
  assign w_oob = 32'(w_x) >= H_RES || 32'(w_y) >= V_RES;
  assign w_wr = |w_grant && !w_oob;
  assign w_offset = w_back_base + ((32'(w_y) * H_RES + 32'(w_x)) << 1);
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  fb_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_block (!r_live || !w_idle || fill_start),
    .i_valid ({req1_valid, req0_valid}),
    .o_grant (w_grant)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_live <= 1'b0;
      r_vsync_d <= 1'b1;
      r_front_sel <= 1'b0;
      r_fill_color <= '0;
      r_fill_base <= '0;
      r_idx <= '0;
      fill_busy <= 1'b0;
      swap_pending <= 1'b0;
      front_base <= '0;
      write_drop <= 1'b0;
      bram_addr <= '0;
      bram_dout <= '0;
      bram_we <= '0;
      bram_en <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_vsync_d <= vga_vsync;
      swap_pending <= w_apply ? 1'b0 : swap_pending || swap_req;
      r_front_sel <= r_front_sel ^ w_apply;
      front_base <= (r_front_sel ^ w_apply) ? BUF_BYTES : 32'd0;
      write_drop <= |w_grant && w_oob;
      if (r_state == FILL) begin
        bram_addr <= r_fill_base + {14'd0, r_idx, 2'b00};
        bram_dout <= {r_fill_color, r_fill_color};
        bram_we <= 4'b1111;
        bram_en <= 1'b1;
        r_idx <= r_idx + 16'd1;
        r_state <= r_idx == 16'(FILL_WORDS - 1) ? IDLE : FILL;
      end else begin
        r_state <= w_start ? FILL : IDLE;
        fill_busy <= w_start;
        if (w_start) begin
          r_fill_color <= fill_color;
          r_fill_base <= w_back_base;
          r_idx <= '0;
        end
        bram_addr <= w_offset & ~32'd3;
        bram_dout <= {w_pix, w_pix};
        bram_we <= w_wr ? (w_x[0] ? 4'b1100 : 4'b0011) : 4'b0000;
        bram_en <= w_wr;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scoreboard bench for the frame-buffer write scheduler.
module tb_fb_write_scheduler;
  localparam logic [31:0] BUF = 32'd153600;
  localparam int WORDS = 38400;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } wr_t;

  logic clk = 1'b0, reset, vga_vsync;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [8:0] req0_x, req1_x;
  logic [7:0] req0_y, req1_y;
  logic [15:0] req0_pixel, req1_pixel, fill_color;
  logic fill_start, fill_busy, swap_req, swap_pending, write_drop, bram_en;
  logic [31:0] front_base, bram_addr, bram_dout;
  logic [3:0] bram_we;

  wr_t q[$];
  int n_checks = 0, n_fail = 0, n_writes = 0;
  bit m_front = 1'b0;

  always #5 clk = ~clk;

  fb_write_scheduler dut (
    .clk(clk), .reset(reset), .vga_vsync(vga_vsync),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_pixel(req0_pixel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_pixel(req1_pixel),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_base(front_base), .write_drop(write_drop),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .bram_we(bram_we), .bram_en(bram_en)
  );

  function automatic wr_t exp_px(input int x, input int y, input logic [15:0] pix, input bit front);
    wr_t e;
    e.a = ((front ? 32'd0 : BUF) + 32'((y * 320 + x) * 2)) & ~32'd3;
    e.d = {pix, pix};
    e.we = (x % 2 == 1) ? 4'b1100 : 4'b0011;
    return e;
  endfunction

  // advance to the next negedge and retire any BRAM write against the scoreboard
  task automatic clk_n();
    wr_t e;
    @(negedge clk);
    if (reset === 1'b1 && bram_we !== 4'd0) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h we=%b, required no write", bram_addr, bram_we);
      end else begin
        e = q.pop_front();
        n_writes++;
        if ({bram_addr, bram_dout, bram_we, bram_en} !== {e.a, e.d, e.we, 1'b1}) begin
          n_fail++;
          $display("FAIL bram_write: got addr=%h dout=%h we=%b en=%b, required addr=%h dout=%h we=%b en=1",
                   bram_addr, bram_dout, bram_we, bram_en, e.a, e.d, e.we);
        end
      end
    end
  endtask

  task automatic drive(input int p, input logic v, input int x, input int y, input logic [15:0] pix);
    if (p == 0) begin
      req0_valid = v; req0_x = x[8:0]; req0_y = y[7:0]; req0_pixel = pix;
    end else begin
      req1_valid = v; req1_x = x[8:0]; req1_y = y[7:0]; req1_pixel = pix;
    end
  endtask

  task automatic wr(input int p, input int x, input int y, input logic [15:0] pix);
    int k = 0;
    drive(p, 1'b1, x, y, pix);
    #1;
    while (!(p == 1 ? req1_ready : req0_ready) && k < 20) begin
      clk_n(); #1; k++;
    end
    n_checks++;
    if (k == 20) begin
      n_fail++;
      $display("FAIL handshake_timeout: port %0d ready stayed 0, required 1", p);
    end else q.push_back(exp_px(x, y, pix, m_front));
    clk_n();
    drive(p, 1'b0, 0, 0, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; vga_vsync = 1'b1; fill_start = 1'b0; fill_color = '0; swap_req = 1'b0;
    drive(0, 1'b1, 0, 0, 16'h1111);
    drive(1, 1'b0, 0, 0, 16'h0);
    repeat (3) clk_n();
    n_checks++;
    if ({bram_we, bram_en, req0_ready, req1_ready, fill_busy, swap_pending, write_drop, front_base} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b en=%b rdy=%b%b busy=%b pend=%b drop=%b front=%h, required all 0",
               bram_we, bram_en, req1_ready, req0_ready, fill_busy, swap_pending, write_drop, front_base);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, bram_we, fill_busy, front_base} !== '0) begin
      n_fail++;
      $display("FAIL first_cycle_after_reset: rdy0=%b we=%b busy=%b front=%h, required 0", req0_ready, bram_we, fill_busy, front_base);
    end
    drive(0, 1'b0, 0, 0, 16'h0);
    clk_n();
    m_front = 1'b0;
  endtask

  task automatic test_single_write();
    wr(0, 1, 0, 16'hF800);
    n_checks++;
    if (write_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: write_drop=%b, required 0", write_drop);
    end
    clk_n();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    wr(1, 2, 1, 16'h07E0);
    drive(0, 1'b1, 3, 1, 16'h1234);
    drive(1, 1'b1, 2, 1, 16'hABCD);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: ready=%b, required %b", i, {req1_ready, req0_ready}, exp);
      end
      if (exp[0]) q.push_back(exp_px(3, 1, 16'h1234, m_front));
      else q.push_back(exp_px(2, 1, 16'hABCD, m_front));
      clk_n();
    end
    drive(0, 1'b0, 0, 0, 16'h0);
    drive(1, 1'b0, 0, 0, 16'h0);
    clk_n();
  endtask

  task automatic test_out_of_range();
    int xs[3] = '{320, 0, 511};
    int ys[3] = '{5, 240, 255};
    for (int i = 0; i < 3; i++) begin
      drive(i % 2, 1'b1, xs[i], ys[i], 16'hDEAD);
      #1;
      n_checks++;
      if ((i % 2 == 1 ? req1_ready : req0_ready) !== 1'b1) begin
        n_fail++;
        $display("FAIL oob_ready[%0d]: ready=0, required 1", i);
      end
      clk_n();
      drive(i % 2, 1'b0, 0, 0, 16'h0);
      n_checks++;
      if ({write_drop, bram_we, bram_en} !== {1'b1, 4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL oob_issue[%0d]: drop=%b we=%b en=%b, required drop=1 we=0000 en=0", i, write_drop, bram_we, bram_en);
      end
      clk_n();
      n_checks++;
      if (write_drop !== 1'b0) begin
        n_fail++;
        $display("FAIL oob_pulse[%0d]: write_drop=%b one cycle later, required 0", i, write_drop);
      end
    end
  endtask

  task automatic test_fill();
    int k = 0;
    bit rdy_bad = 0;
    logic [31:0] base = m_front ? 32'd0 : BUF;
    drive(0, 1'b1, 5, 5, 16'h0F0F);
    drive(1, 1'b1, 6, 6, 16'hF0F0);
    fill_start = 1'b1; fill_color = 16'h001F;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL fill_start_block: ready=%b, required 00", {req1_ready, req0_ready});
    end
    for (int i = 0; i < WORDS; i++) q.push_back({base + 32'(4 * i), 32'h001F001F, 4'b1111});
    n_writes = 0;
    clk_n();
    fill_start = 1'b0; fill_color = 16'h0;
    n_checks++;
    if (fill_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_busy_rise: fill_busy=%b, required 1", fill_busy);
    end
    while (k < WORDS + 20) begin
      clk_n(); k++;
      if (fill_busy !== 1'b1) begin
        drive(0, 1'b0, 0, 0, 16'h0);
        drive(1, 1'b0, 0, 0, 16'h0);
        break;
      end
      if ({req1_ready, req0_ready} !== 2'b00) rdy_bad = 1;
      fill_start = (k == 100); fill_color = (k == 100) ? 16'hFFFF : 16'h0;
      swap_req = (k == 150);
      vga_vsync = !(k >= 200 && k < 203);
      if (k == 300) begin
        n_checks++;
        if ({swap_pending, front_base} !== {1'b1, 32'd0}) begin
          n_fail++;
          $display("FAIL swap_during_fill: pend=%b front=%h, required pend=1 front=0", swap_pending, front_base);
        end
      end
    end
    n_checks++;
    if (k >= WORDS + 20 || rdy_bad) begin
      n_fail++;
      $display("FAIL fill_run: cycles=%0d ready_seen=%0d, required busy to fall and readies 0", k, rdy_bad);
    end
    n_checks++;
    if (n_writes != WORDS || q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_count: writes=%0d left=%0d, required %0d and 0", n_writes, q.size(), WORDS);
    end
    clk_n();
  endtask

  task automatic test_swap_deferred();
    repeat (3) clk_n();
    n_checks++;
    if ({swap_pending, front_base} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL swap_after_fill_held: pend=%b front=%h, required pend=1 front=0", swap_pending, front_base);
    end
    vga_vsync = 1'b0;
    clk_n();
    m_front = 1'b1;
    n_checks++;
    if ({swap_pending, front_base} !== {1'b0, BUF}) begin
      n_fail++;
      $display("FAIL swap_apply: pend=%b front=%h, required pend=0 front=%h", swap_pending, front_base, BUF);
    end
    vga_vsync = 1'b1;
    wr(0, 0, 0, 16'hAAAA);
  endtask

  task automatic test_idle_swap();
    swap_req = 1'b1;
    clk_n();
    swap_req = 1'b0;
    clk_n();
    swap_req = 1'b1;
    clk_n();
    swap_req = 1'b0;
    repeat (3) clk_n();
    n_checks++;
    if ({swap_pending, front_base} !== {1'b1, BUF}) begin
      n_fail++;
      $display("FAIL idle_swap_pending: pend=%b front=%h, required pend=1 front=%h", swap_pending, front_base, BUF);
    end
    vga_vsync = 1'b0;
    drive(0, 1'b1, 4, 0, 16'h3C3C);
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_same_cycle_ready: ready=%b, required 1", req0_ready);
    end
    q.push_back(exp_px(4, 0, 16'h3C3C, m_front));
    clk_n();
    drive(0, 1'b0, 0, 0, 16'h0);
    m_front = 1'b0;
    n_checks++;
    if ({swap_pending, front_base} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL idle_swap_apply: pend=%b front=%h, required pend=0 front=0", swap_pending, front_base);
    end
    vga_vsync = 1'b1;
    clk_n();
    wr(0, 319, 239, 16'h5A5A);
    clk_n();
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] base = m_front ? 32'd0 : BUF;
    fill_start = 1'b1; fill_color = 16'hF0F0;
    for (int i = 0; i < WORDS; i++) q.push_back({base + 32'(4 * i), 32'hF0F0F0F0, 4'b1111});
    clk_n();
    fill_start = 1'b0;
    repeat (50) clk_n();
    reset = 1'b0;
    clk_n();
    q.delete();
    n_checks++;
    if ({bram_we, bram_en, fill_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_fill: we=%b en=%b busy=%b, required 0", bram_we, bram_en, fill_busy);
    end
    clk_n();
    reset = 1'b1;
    repeat (20) clk_n();
    n_checks++;
    if ({fill_busy, front_base, swap_pending} !== '0) begin
      n_fail++;
      $display("FAIL after_reset_idle: busy=%b front=%h pend=%b, required 0", fill_busy, front_base, swap_pending);
    end
    m_front = 1'b0;
    wr(1, 10, 0, 16'h4242);
    clk_n();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_out_of_range();
    test_fill();
    test_swap_deferred();
    test_idle_swap();
    test_reset_mid_fill();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
